instruction_cache: RTL and testbench

Direct-mapped, one-word-per-line instruction cache between the instruction fetch unit and the memory controller's icache port. Hits answer in one cycle from internal arrays. Misses issue a single word fetch to the memory controller, fill the line, and return the word. A misprediction clear aborts any outstanding miss without corrupting cache contents.

---
 rtl/instruction_cache_if.sv | 23 ++
 rtl/instruction_cache.sv | 98 +++++++++
 tb/tb_instruction_cache.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/instruction_cache_if.sv
// Fetch-unit and memory-controller signals seen by the instruction cache.
// The cache takes the slave view; the environment driving it takes the master view.
interface instruction_cache_if;
  logic        clearIn;
  logic        fetchFlag;
  logic [31:0] fetchAddr;
  logic        fetchOk;
  logic [31:0] fetchInst;
  logic        memFlag;
  logic [31:0] memAddr;
  logic        memOk;
  logic [31:0] memData;

  modport slave (
    input  clearIn, fetchFlag, fetchAddr, memOk, memData,
    output fetchOk, fetchInst, memFlag, memAddr
  );

  modport master (
    output clearIn, fetchFlag, fetchAddr, memOk, memData,
    input  fetchOk, fetchInst, memFlag, memAddr
  );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped, one-word-per-line instruction cache. Hits return in one cycle;
// misses fetch a single word from the memory controller and fill the line.
module instruction_cache #(
  parameter int INDEX_BITS = 4
) (
  input  logic                clockIn,
  input  logic                resetIn,
  instruction_cache_if.slave  bus
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic {IDLE, MISS} state_e;

  state_e                  state_q, state_d;
  logic [29:0]             req_word_q, req_word_d;
  logic                    fetch_ok_q, fetch_ok_d;
  logic [31:0]             fetch_inst_q, fetch_inst_d;
  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [31:0]             data_q [LINES];
  logic                    fill_en;

  logic [INDEX_BITS-1:0]   lk_idx, req_idx;
  logic [TAG_W-1:0]        lk_tag, req_tag;
  logic                    lk_hit;

  assign lk_idx  = bus.fetchAddr[INDEX_BITS+1:2];
  assign lk_tag  = bus.fetchAddr[31:INDEX_BITS+2];
  assign req_idx = req_word_q[INDEX_BITS-1:0];
  assign req_tag = req_word_q[29:INDEX_BITS];
  assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  always_comb begin
    state_d      = state_q;
    req_word_d   = req_word_q;
    fetch_ok_d   = 1'b0;
    fetch_inst_d = fetch_inst_q;
    fill_en      = 1'b0;
    if (bus.clearIn) begin
      // Flush drops any pending miss; the line is never written.
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.fetchFlag) begin
            req_word_d = bus.fetchAddr[31:2];
            if (lk_hit) begin
              fetch_ok_d   = 1'b1;
              fetch_inst_d = data_q[lk_idx];
            end else begin
              state_d = MISS;
            end
          end
        end
        MISS: begin
          if (bus.memOk) begin
            fill_en      = 1'b1;
            fetch_ok_d   = 1'b1;
            fetch_inst_d = bus.memData;
            state_d      = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      state_q      <= IDLE;
      req_word_q   <= '0;
      fetch_ok_q   <= 1'b0;
      fetch_inst_q <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_word_q   <= req_word_d;
      fetch_ok_q   <= fetch_ok_d;
      fetch_inst_q <= fetch_inst_d;
      if (fill_en) valid_q[req_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clockIn) begin
    if (fill_en) begin
      tag_q[req_idx]  <= req_tag;
      data_q[req_idx] <= bus.memData;
    end
  end

  // memFlag falls combinationally with memOk so the controller never sees a
  // request lingering into its next idle cycle.
  assign bus.memFlag   = (state_q == MISS) & ~bus.memOk;
  assign bus.memAddr   = {req_word_q, 2'b00};
  assign bus.fetchOk   = fetch_ok_q;
  assign bus.fetchInst = fetch_inst_q;
endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache with a memory-controller model and an
// expected-instruction queue popped whenever fetchOk pulses.
module tb_instruction_cache;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instruction_cache_if bus();
  instruction_cache #(.INDEX_BITS(4)) dut (.clockIn(clk), .resetIn(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  bit          ok_seen;
  bit          mc_auto = 1'b0;
  bit          mc_busy = 1'b0;
  int          mc_cnt  = 0;
  logic [31:0] mc_addr = '0;
  int          fetches = 0;
  bit          mv [16];
  logic [25:0] mt [16];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs on the falling edge, then advance the controller model.
  task automatic cyc();
    logic [31:0] e;
    @(negedge clk);
    ok_seen = bus.fetchOk;
    if (bus.fetchOk) begin
      if (exp_q.size() == 0) chk("unexpected_fetchOk", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("fetchInst", bus.fetchInst, e);
      end
    end
    if (mc_auto) begin
      if (bus.memOk) begin
        bus.memOk = 1'b0;
        mc_busy   = 1'b0;
      end else if (mc_busy) begin
        if (mc_cnt > 1) mc_cnt--;
        else begin
          bus.memOk   = 1'b1;
          bus.memData = mem_word(mc_addr);
          #1;
          chk("memFlag_drop_with_memOk", {31'd0, bus.memFlag}, 32'd0);
        end
      end
      if (!mc_busy && !bus.memOk && bus.memFlag) begin
        mc_busy = 1'b1;
        mc_addr = bus.memAddr;
        mc_cnt  = $urandom_range(1, 3);
        fetches++;
      end
    end
  endtask

  task automatic fetch_hit(input logic [31:0] a);
    int f0;
    f0 = fetches;
    bus.fetchFlag = 1'b1;
    bus.fetchAddr = a;
    exp_q.push_back(mem_word(a));
    cyc();
    bus.fetchFlag = 1'b0;
    chk("hit_latency", {31'd0, ok_seen}, 32'd1);
    chk("hit_no_memFlag", {31'd0, bus.memFlag}, 32'd0);
    cyc();
    chk("hit_single_pulse", {31'd0, ok_seen}, 32'd0);
    chk("hit_no_fetch", fetches, f0);
  endtask

  task automatic fetch_miss(input logic [31:0] a);
    int f0;
    bit was_ok;
    bit done;
    f0 = fetches;
    done = 1'b0;
    bus.fetchFlag = 1'b1;
    bus.fetchAddr = a;
    exp_q.push_back(mem_word(a));
    cyc();
    bus.fetchFlag = 1'b0;
    chk("miss_no_ok", {31'd0, ok_seen}, 32'd0);
    chk("miss_memFlag", {31'd0, bus.memFlag}, 32'd1);
    chk("miss_memAddr", bus.memAddr, {a[31:2], 2'b00});
    for (int i = 0; i < 20 && !done; i++) begin
      was_ok = bus.memOk;
      cyc();
      if (was_ok) begin
        chk("miss_ok_latency", {31'd0, ok_seen}, 32'd1);
        done = 1'b1;
      end
    end
    if (!done) chk("miss_timeout", 32'd0, 32'd1);
    cyc();
    chk("miss_single_pulse", {31'd0, ok_seen}, 32'd0);
    chk("one_fetch_per_miss", fetches, f0 + 1);
    mv[a[5:2]] = 1'b1;
    mt[a[5:2]] = a[31:6];
  endtask

  initial begin
    logic [31:0] a;
    int miss_cnt;
    int f_start;
    bus.clearIn = 1'b0; bus.fetchFlag = 1'b0; bus.fetchAddr = '0;
    bus.memOk = 1'b0;   bus.memData = '0;
    foreach (mv[i]) mv[i] = 1'b0;

    // Reset state
    cyc(); cyc();
    chk("rst_fetchOk", {31'd0, bus.fetchOk}, 32'd0);
    chk("rst_fetchInst", bus.fetchInst, 32'd0);
    chk("rst_memFlag", {31'd0, bus.memFlag}, 32'd0);
    chk("rst_memAddr", bus.memAddr, 32'd0);
    rst_n = 1'b1;
    mc_auto = 1'b1;

    // Cold miss, then hits on the filled line
    fetch_miss(32'h0000_0000);
    fetch_hit(32'h0000_0000);
    fetch_hit(32'h0000_0002);

    // Same-index conflict
    fetch_miss(32'h0000_0004);
    fetch_hit(32'h0000_0004);
    fetch_miss(32'h0000_0044);
    fetch_miss(32'h0000_0004);

    // Back-to-back hits, the second issued during the first fetchOk
    bus.fetchFlag = 1'b1; bus.fetchAddr = 32'h0;
    exp_q.push_back(mem_word(32'h0));
    cyc();
    chk("b2b_first", {31'd0, ok_seen}, 32'd1);
    bus.fetchAddr = 32'h4;
    exp_q.push_back(mem_word(32'h4));
    cyc();
    bus.fetchFlag = 1'b0;
    chk("b2b_second", {31'd0, ok_seen}, 32'd1);
    cyc();
    chk("b2b_end", {31'd0, ok_seen}, 32'd0);

    // Flush during a miss; late memOk in IDLE must be ignored
    mc_auto = 1'b0;
    bus.fetchFlag = 1'b1; bus.fetchAddr = 32'h100;
    cyc();
    bus.fetchFlag = 1'b0;
    chk("clr_pre_memFlag", {31'd0, bus.memFlag}, 32'd1);
    bus.clearIn = 1'b1;
    cyc();
    bus.clearIn = 1'b0;
    chk("clr_memFlag", {31'd0, bus.memFlag}, 32'd0);
    chk("clr_fetchOk", {31'd0, ok_seen}, 32'd0);
    bus.memOk = 1'b1; bus.memData = 32'hDEAD_BEEF;
    cyc();
    bus.memOk = 1'b0;
    cyc();
    chk("idle_memOk_no_ok", {31'd0, ok_seen}, 32'd0);
    chk("idle_memOk_no_flag", {31'd0, bus.memFlag}, 32'd0);
    bus.clearIn = 1'b1; bus.fetchFlag = 1'b1; bus.fetchAddr = 32'h100;
    cyc();
    bus.clearIn = 1'b0; bus.fetchFlag = 1'b0;
    chk("clr_ignores_fetch", {31'd0, bus.memFlag}, 32'd0);
    mc_auto = 1'b1;
    fetch_miss(32'h0000_0100);

    // Random traffic: count exactly one controller fetch per miss
    miss_cnt = 0;
    f_start = fetches;
    for (int i = 0; i < 200 && miss_cnt < 20; i++) begin
      a = $urandom & 32'h0000_0FFF;
      if (mv[a[5:2]] && mt[a[5:2]] == a[31:6]) fetch_hit(a);
      else begin
        fetch_miss(a);
        miss_cnt++;
      end
    end
    chk("random_miss_count", miss_cnt, 32'd20);
    chk("random_fetch_total", fetches - f_start, miss_cnt);

    // Asynchronous reset in the middle of a miss
    mc_auto = 1'b0;
    bus.fetchFlag = 1'b1; bus.fetchAddr = 32'h200;
    cyc();
    bus.fetchFlag = 1'b0;
    chk("arst_pre_memFlag", {31'd0, bus.memFlag}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_memFlag", {31'd0, bus.memFlag}, 32'd0);
    chk("arst_fetchOk", {31'd0, bus.fetchOk}, 32'd0);
    chk("arst_memAddr", bus.memAddr, 32'd0);
    cyc();
    rst_n = 1'b1;
    foreach (mv[i]) mv[i] = 1'b0;
    mc_busy = 1'b0; mc_auto = 1'b1;
    fetch_miss(32'h0000_0000);
    fetch_miss(32'h0000_0004);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
